// File: rtl/axi_xbar_pkg.sv
// Shared crossbar types: AXI field widths, the packed write-data FIFO entry and the
// W-drain state encoding.
package axi_xbar_pkg;

   localparam int unsigned AXI_LEN_WIDTH  = 8;
   localparam int unsigned AXI_DATA_WIDTH = 32;
   localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

   typedef logic [AXI_LEN_WIDTH-1:0] axi_len_t;

   // Layout shared by the FIFO writer and the drain: strobes above data.
   typedef struct packed {
      logic [AXI_STRB_WIDTH-1:0] strb;
      logic [AXI_DATA_WIDTH-1:0] data;
   } w_entry_t;

   typedef enum logic [0:0] {
      IDLE,
      BURST
   } drain_state_e;

endpackage

// File: rtl/axi_w_burst_drain_if.sv
// Command, write-data FIFO read port and AXI W channel seen by the burst drain.
// master = the drain itself, slave = the surrounding crossbar / slave port.
interface axi_w_burst_drain_if
   import axi_xbar_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH,
   parameter int unsigned LEN_WIDTH  = AXI_LEN_WIDTH
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                           cmd_valid;
   logic                           cmd_ready;
   logic [LEN_WIDTH-1:0]           cmd_len;

   logic                           fifo_empty;
   logic [STRB_WIDTH+DATA_WIDTH-1:0] fifo_rdata;
   logic                           fifo_rd_en;

   logic                           w_valid;
   logic                           w_ready;
   logic [DATA_WIDTH-1:0]          w_data;
   logic [STRB_WIDTH-1:0]          w_strb;
   logic                           w_last;

   modport master (
      input  cmd_valid, cmd_len, fifo_empty, fifo_rdata, w_ready,
      output cmd_ready, fifo_rd_en, w_valid, w_data, w_strb, w_last
   );

   modport slave (
      output cmd_valid, cmd_len, fifo_empty, fifo_rdata, w_ready,
      input  cmd_ready, fifo_rd_en, w_valid, w_data, w_strb, w_last
   );

endinterface

// File: rtl/axi_w_burst_drain.sv
// Drains len+1 {strb,data} entries from the write-data FIFO onto a registered AXI W
// channel, one burst command at a time. DATA_WIDTH must be a multiple of 8.
module axi_w_burst_drain
   import axi_xbar_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH,
   parameter int unsigned LEN_WIDTH  = AXI_LEN_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   axi_w_burst_drain_if.master    bus,
   output logic                   burst_done,
   output logic                   busy
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   drain_state_e            state_q, state_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   // One bit wider than len so that len=255 counts to 256 without wrapping.
   logic [LEN_WIDTH:0]      beat_cnt_q, beat_cnt_d;
   logic                    w_valid_q, w_valid_d;
   logic                    w_last_q, w_last_d;
   logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
   logic [STRB_WIDTH-1:0]   w_strb_q, w_strb_d;
   logic                    done_q, done_d;
   logic                    load;
   logic                    beats_left;

   assign beats_left = (beat_cnt_q <= {1'b0, len_q});

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      beat_cnt_d = beat_cnt_q;
      w_valid_d  = w_valid_q;
      w_last_d   = w_last_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      done_d     = 1'b0;
      load       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               len_d      = bus.cmd_len;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            // Gated by rst_n so a reset edge never steals a FIFO entry.
            load = rst_n && !bus.fifo_empty && beats_left && (!w_valid_q || bus.w_ready);
            if (load) begin
               w_data_d   = bus.fifo_rdata[DATA_WIDTH-1:0];
               w_strb_d   = bus.fifo_rdata[STRB_WIDTH+DATA_WIDTH-1 -: STRB_WIDTH];
               w_valid_d  = 1'b1;
               w_last_d   = (beat_cnt_q == {1'b0, len_q});
               beat_cnt_d = beat_cnt_q + (LEN_WIDTH+1)'(1);
            end else if (w_valid_q && bus.w_ready) begin
               w_valid_d = 1'b0;
               w_last_d  = 1'b0;
            end
            if (w_valid_q && bus.w_ready && w_last_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         beat_cnt_q <= '0;
         w_valid_q  <= 1'b0;
         w_last_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         beat_cnt_q <= beat_cnt_d;
         w_valid_q  <= w_valid_d;
         w_last_q   <= w_last_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         done_q     <= done_d;
      end
   end

   assign bus.cmd_ready  = (state_q == IDLE);
   assign bus.fifo_rd_en = load;
   assign bus.w_valid    = w_valid_q;
   assign bus.w_last     = w_last_q;
   assign bus.w_data     = w_data_q;
   assign bus.w_strb     = w_strb_q;
   assign burst_done     = done_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_axi_w_burst_drain.sv
// Bench for axi_w_burst_drain: directed vector table, reset-abort sequence and a random
// run, all scored against a stream-level model of FIFO order, burst lengths and timing.
module tb_axi_w_burst_drain;
   import axi_xbar_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic burst_done;
   logic busy;

   always #5 clk = ~clk;

   axi_w_burst_drain_if #(.DATA_WIDTH(32), .LEN_WIDTH(8)) bus ();

   axi_w_burst_drain #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .burst_done (burst_done),
      .busy       (busy)
   );

   typedef struct {
      int len;
      int preload;
      int stall_start;
      int stall_cycles;
      int push_delay;
      int push_cnt;
      int exp_beats;
      int exp_done;
      int exp_left;
   } vec_t;

   int checks = 0;
   int errors = 0;

   w_entry_t fifo_q[$];
   w_entry_t exp_q[$];
   int unsigned seq = 1;

   // Model state: what the drain should be doing, derived from accepted commands.
   bit          exp_busy = 0;
   bit          pend_done = 0;
   bit          prev_stall = 0;
   int          cur_len = 0;
   int          beats_in = 0;
   int          pops_in = 0;
   int          hs_count = 0;
   int          done_count = 0;
   logic [31:0] prev_data;
   logic [3:0]  prev_strb;
   logic        prev_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic refresh();
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic push(input bit rand_strb);
      w_entry_t e;
      e.data = {16'hA5A5, seq[15:0]};
      e.strb = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
      seq++;
      fifo_q.push_back(e);
      exp_q.push_back(e);
      refresh();
   endtask

   task automatic flush();
      fifo_q.delete();
      exp_q.delete();
      refresh();
   endtask

   task automatic monitor();
      w_entry_t e;
      bit ok;
      if (!rst_n) begin
         check("rd_en_in_reset", bus.fifo_rd_en, 1'b0);
         exp_busy   = 0;
         pend_done  = 0;
         prev_stall = 0;
         return;
      end
      check("burst_done", burst_done, pend_done);
      if (burst_done) done_count++;
      check("busy", busy, exp_busy);
      check("cmd_ready", bus.cmd_ready, !exp_busy);
      if (!exp_busy) check("w_valid_idle", bus.w_valid, 1'b0);
      if (prev_stall) begin
         check("hold_valid", bus.w_valid, 1'b1);
         check("hold_data", bus.w_data, prev_data);
         check("hold_strb", bus.w_strb, prev_strb);
         check("hold_last", bus.w_last, prev_last);
      end
      if (bus.fifo_rd_en) begin
         ok = exp_busy && !bus.fifo_empty && (pops_in <= cur_len) && !(bus.w_valid && !bus.w_ready);
         check("rd_en_legal", ok, 1'b1);
         pops_in++;
      end
      pend_done = 0;
      if (bus.w_valid && bus.w_ready) begin
         hs_count++;
         if (exp_q.size() == 0) begin
            check("beat_unexpected", 1'b1, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("w_data", bus.w_data, e.data);
            check("w_strb", bus.w_strb, e.strb);
         end
         check("w_last", bus.w_last, beats_in == cur_len);
         beats_in++;
         if (beats_in > cur_len) begin
            pend_done = 1;
            exp_busy  = 0;
         end
      end else if (bus.cmd_valid && !exp_busy) begin
         exp_busy = 1;
         cur_len  = int'(bus.cmd_len);
         beats_in = 0;
         pops_in  = 0;
      end
      prev_stall = bus.w_valid && !bus.w_ready;
      prev_data  = bus.w_data;
      prev_strb  = bus.w_strb;
      prev_last  = bus.w_last;
   endtask

   // Sample at negedge, then advance to just past the posedge and apply the FIFO pop.
   task automatic tick();
      bit pop;
      @(negedge clk);
      monitor();
      pop = bus.fifo_rd_en;
      @(posedge clk);
      #1;
      if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      refresh();
   endtask

   task automatic run_vec(input vec_t v);
      int done_tick;
      int hs0;
      int dc;
      flush();
      for (int i = 0; i < v.preload; i++) push(1'b0);
      bus.cmd_len   = 8'(v.len);
      bus.cmd_valid = 1'b1;
      bus.w_ready   = 1'b1;
      hs0 = hs_count;
      tick();
      bus.cmd_valid = 1'b0;
      done_tick = -1;
      for (int t = 1; t <= v.len + 300 && done_tick < 0; t++) begin
         bus.w_ready = !(t >= v.stall_start && t < v.stall_start + v.stall_cycles);
         dc = done_count;
         tick();
         if (done_count != dc) done_tick = t;
         if (t == v.push_delay) for (int i = 0; i < v.push_cnt; i++) push(1'b0);
      end
      check("done_tick", done_tick, v.exp_done);
      check("beat_count", hs_count - hs0, v.exp_beats);
      check("fifo_left", fifo_q.size(), v.exp_left);
      bus.w_ready = 1'b1;
      tick();
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{len: 0,   preload: 1,   stall_start: 0, stall_cycles: 0, push_delay: 0,
                  push_cnt: 0, exp_beats: 1,   exp_done: 3,   exp_left: 0};
      vecs[1] = '{len: 3,   preload: 4,   stall_start: 0, stall_cycles: 0, push_delay: 0,
                  push_cnt: 0, exp_beats: 4,   exp_done: 6,   exp_left: 0};
      vecs[2] = '{len: 2,   preload: 3,   stall_start: 2, stall_cycles: 3, push_delay: 0,
                  push_cnt: 0, exp_beats: 3,   exp_done: 8,   exp_left: 0};
      vecs[3] = '{len: 1,   preload: 1,   stall_start: 0, stall_cycles: 0, push_delay: 5,
                  push_cnt: 1, exp_beats: 2,   exp_done: 8,   exp_left: 0};
      vecs[4] = '{len: 255, preload: 256, stall_start: 0, stall_cycles: 0, push_delay: 0,
                  push_cnt: 0, exp_beats: 256, exp_done: 258, exp_left: 0};
      vecs[5] = '{len: 1,   preload: 3,   stall_start: 0, stall_cycles: 0, push_delay: 0,
                  push_cnt: 0, exp_beats: 2,   exp_done: 4,   exp_left: 1};
      vecs[6] = '{len: 1,   preload: 2,   stall_start: 3, stall_cycles: 2, push_delay: 0,
                  push_cnt: 0, exp_beats: 2,   exp_done: 6,   exp_left: 0};

      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.w_ready   = 1'b0;
      refresh();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_w_valid", bus.w_valid, 1'b0);
      check("rst_w_last", bus.w_last, 1'b0);
      check("rst_w_data", bus.w_data, 32'h0);
      check("rst_w_strb", bus.w_strb, 4'h0);
      check("rst_burst_done", burst_done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cmd_ready", bus.cmd_ready, 1'b1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset after the second beat of a len=7 burst, then a fresh single-beat burst.
      flush();
      for (int i = 0; i < 8; i++) push(1'b0);
      bus.cmd_len   = 8'd7;
      bus.cmd_valid = 1'b1;
      bus.w_ready   = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q = fifo_q;
      check("fifo_untouched", fifo_q.size(), 5);
      check("abort_w_valid", bus.w_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_cmd_ready", bus.cmd_ready, 1'b1);
      begin
         int hs0;
         int dc;
         hs0 = hs_count;
         dc  = done_count;
         bus.cmd_len   = 8'd0;
         bus.cmd_valid = 1'b1;
         tick();
         bus.cmd_valid = 1'b0;
         for (int t = 0; t < 20 && done_count == dc; t++) tick();
         check("post_abort_done", done_count - dc, 1);
         check("post_abort_beats", hs_count - hs0, 1);
      end

      // Random traffic: random backpressure, FIFO fill and commands, including while busy.
      flush();
      for (int c = 0; c < 4000; c++) begin
         bus.w_ready   = ($urandom_range(0, 3) != 0);
         bus.cmd_valid = ($urandom_range(0, 3) == 0);
         bus.cmd_len   = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 40) push(1'b1);
         tick();
      end
      bus.cmd_valid = 1'b0;
      bus.w_ready   = 1'b1;
      for (int c = 0; c < 2000 && exp_busy; c++) begin
         if (fifo_q.size() < 4) push(1'b1);
         tick();
      end
      check("random_drain_idle", exp_busy, 1'b0);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
